barrel_align: RTL and testbench
===============================

# barrel_align

Word aligner that receives an 8-bit stream whose words have been cyclically left-rotated by an unknown constant amount (0-7) and recovers the rotation. It hunts for a known sync word that repeats once per frame, tries one candidate rotation at a time, and verifies the frame position before locking. It then emits every word cyclically right-rotated by the locked amount, undoing the upstream rotation. It sits on the receive side of the rotated-word link, directly after the link register and ahead of frame-level consumers.

## Interface
- SYNC_WORD, 8'hA5, sync pattern after de-rotation
- FRAME_LEN, 16, valid words per frame including the sync word (>= 2)
- LOCK_COUNT, 4, consecutive sync hits (including the first) required to lock
- LOSS_COUNT, 3, consecutive sync misses while locked required to drop lock

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data valid this cycle
- in_data  in  8  rotated input word
- out_valid  out  1  out_data valid
- out_data  out  8  de-rotated word
- out_sof  out  1  out_data is the sync word at frame position 0 (only while locked)
- locked  out  1  alignment locked
- rot  out  3  current candidate or locked rotation amount

## Operation
- rotr(x,k) = {x[k-1:0], x[7:k]}; rotr(x,0) = x. match = (rotr(in_data, rot) == SYNC_WORD).
- Internal counters:
  - pos: frame position, 0..FRAME_LEN-1.
  - win: search window, 0..FRAME_LEN-1.
  - hits: 0..LOCK_COUNT.
  - miss: 0..LOSS_COUNT.
- All state changes only on cycles with in_valid=1. With in_valid=0, nothing changes except out_valid/out_sof, which go 0.
- States:
  - SEARCH (reset state):
    - On match: go to VERIFY, hits=1, pos=1.
    - Otherwise win++.
    - If win reaches FRAME_LEN-1 without a match, set rot = rot+1 (7 wraps to 0) and win=0.
  - VERIFY:
    - pos advances modulo FRAME_LEN.
    - At a word with pos==0, on match: hits++. If hits reaches LOCK_COUNT, go to LOCKED with miss=0.
    - At a word with pos==0, on mismatch: go to SEARCH with rot+1, win=0, hits=0.
    - Words with pos!=0 are not checked.
  - LOCKED:
    - pos advances; rot is frozen; locked=1.
    - At pos==0, on match: miss=0.
    - At pos==0, on mismatch: miss++. If miss reaches LOSS_COUNT, go to SEARCH keeping rot, with win=0, miss=0, and locked drops.
- Output datapath:
  - out_data = rotr(in_data, rot), using the rot value held before this cycle's update.
  - out_valid = in_valid.
  - out_sof = in_valid & pos==0 & state==LOCKED & match.
- Data is passed through in every state. Consumers qualify it with locked.

## Timing
- Output latency is one cycle: out_* is registered from the in_* values of the previous cycle.
- locked is registered. It rises on the cycle after the LOCK_COUNT-th hit is sampled and falls on the cycle after the LOSS_COUNT-th miss is sampled.
- Reset values: out_valid=0, out_data=8'h00, out_sof=0, locked=0, rot=0, state=SEARCH, and every counter 0.
- rst has priority over in_valid. A reset asserted mid-frame or while locked clears lock on the next edge, and any word presented in that cycle is dropped (out_valid=0).
- Worst-case lock time with a clean stream: 8*FRAME_LEN + LOCK_COUNT*FRAME_LEN valid words.
- A false match in payload during SEARCH costs at most one frame in VERIFY before the search resumes.

## Configuration
- BARREL_ALIGN_STATS_EN defined:
  - Adds output port slip_cnt (out, 8 bits).
  - slip_cnt is a saturating count of LOCKED→SEARCH transitions; reset 0; holds at 8'hFF.
- BARREL_ALIGN_STATS_EN undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Default params, frames of {8'h2D, 15×8'h00} (SYNC left-rotated by 3), continuous in_valid:
  - locked=1, rot=3.
  - out_sof=1 with out_data=8'hA5 once per 16 words.
  - Payload appears as 8'h00.
- Same stream with rotation 0, frames {8'hA5, 15×8'h00}: locks with rot=0 after exactly 4 frames; out_data equals in_data delayed one cycle.
- Locked at rot=3, then corrupt the sync word (8'h00) in 2 consecutive frames, then restore it: locked stays 1 and miss clears.
- Locked at rot=3, then corrupt the sync in 3 consecutive frames:
  - locked falls one cycle after the third miss.
  - With stats enabled, slip_cnt increments to 1.
  - Relock occurs with rot=3.
- Random in_valid gaps (50% duty) on the rot=5 stream (sync appears as 8'hB4): lock is achieved with rot=5, and out_valid mirrors in_valid delayed one cycle.
- Assert rst for one cycle while locked: the next cycle shows locked=0, rot=0, out_valid=0; relock then follows the normal sequence.

Source files
------------

// File: rtl/barrel_align_if.sv
// Stream-side signals of the barrel aligner. slip_cnt exists only when
// BARREL_ALIGN_STATS_EN is defined.
interface barrel_align_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sof;
  logic       locked;
  logic [2:0] rot;
`ifdef BARREL_ALIGN_STATS_EN
  logic [7:0] slip_cnt;

  modport master (output in_valid, in_data,
                  input  out_valid, out_data, out_sof, locked, rot, slip_cnt);
  modport slave  (input  in_valid, in_data,
                  output out_valid, out_data, out_sof, locked, rot, slip_cnt);
`else
  modport master (output in_valid, in_data,
                  input  out_valid, out_data, out_sof, locked, rot);
  modport slave  (input  in_valid, in_data,
                  output out_valid, out_data, out_sof, locked, rot);
`endif
endinterface

// File: rtl/barrel_align.sv
// Rotation-recovering word aligner: hunts for SYNC_WORD over 8 candidate rotations,
// verifies frame position, locks, and de-rotates. Optional macro: BARREL_ALIGN_STATS_EN.
//
// state    | meaning
// S_SEARCH | trying one rotation for FRAME_LEN words, advancing on no match
// S_VERIFY | candidate found, confirming sync at every frame position 0
// S_LOCKED | rotation frozen, counting consecutive sync misses
module barrel_align #(
  parameter logic [7:0] SYNC_WORD  = 8'hA5,
  parameter int         FRAME_LEN  = 16,
  parameter int         LOCK_COUNT = 4,
  parameter int         LOSS_COUNT = 3
) (
  input  logic         clk,
  input  logic         rst,
  barrel_align_if.slave bus
);

  localparam int PW = $clog2(FRAME_LEN);
  localparam int HW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(LOSS_COUNT + 1);

  typedef enum logic [1:0] {S_SEARCH, S_VERIFY, S_LOCKED} state_t;

  state_t          state_q, state_d;
  logic [2:0]      rot_q, rot_d;
  logic [PW-1:0]   pos_q, pos_d, pos_next;
  logic [PW-1:0]   win_q, win_d;
  logic [HW-1:0]   hits_q, hits_d;
  logic [MW-1:0]   miss_q, miss_d;
  logic            locked_q, locked_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_sof_q, out_sof_d;
  logic [7:0]      slip_q, slip_d;
  logic [7:0]      derot;
  logic            match;

  function automatic logic [7:0] rotr(input logic [7:0] x, input logic [2:0] k);
    logic [15:0] dbl;
    dbl = {x, x} >> k;
    return dbl[7:0];
  endfunction

  assign derot    = rotr(bus.in_data, rot_q);
  assign match    = (derot == SYNC_WORD);
  assign pos_next = (pos_q == PW'(FRAME_LEN - 1)) ? '0 : pos_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rot_d       = rot_q;
    pos_d       = pos_q;
    win_d       = win_q;
    hits_d      = hits_q;
    miss_d      = miss_q;
    slip_d      = slip_q;
    out_valid_d = bus.in_valid;
    out_data_d  = bus.in_valid ? derot : out_data_q;
    out_sof_d   = bus.in_valid && (pos_q == '0) && (state_q == S_LOCKED) && match;

    if (bus.in_valid) begin
      unique case (state_q)
        S_SEARCH: begin
          if (match) begin
            state_d = (LOCK_COUNT == 1) ? S_LOCKED : S_VERIFY;
            hits_d  = HW'(1);
            pos_d   = PW'(1);
            miss_d  = '0;
          end else if (win_q == PW'(FRAME_LEN - 1)) begin
            rot_d = rot_q + 3'd1;
            win_d = '0;
          end else begin
            win_d = win_q + 1'b1;
          end
        end
        S_VERIFY: begin
          pos_d = pos_next;
          if (pos_q == '0) begin
            if (match) begin
              hits_d = hits_q + 1'b1;
              if (hits_q == HW'(LOCK_COUNT - 1)) begin
                state_d = S_LOCKED;
                miss_d  = '0;
              end
            end else begin
              state_d = S_SEARCH;
              rot_d   = rot_q + 3'd1;
              win_d   = '0;
              hits_d  = '0;
            end
          end
        end
        S_LOCKED: begin
          pos_d = pos_next;
          if (pos_q == '0) begin
            if (match) begin
              miss_d = '0;
            end else if (miss_q == MW'(LOSS_COUNT - 1)) begin
              // Rotation is kept: a burst of bit errors usually leaves it valid.
              state_d = S_SEARCH;
              win_d   = '0;
              miss_d  = '0;
              hits_d  = '0;
              if (slip_q != 8'hFF) slip_d = slip_q + 8'd1;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
        default: state_d = S_SEARCH;
      endcase
    end
    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SEARCH;
      rot_q       <= '0;
      pos_q       <= '0;
      win_q       <= '0;
      hits_q      <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_sof_q   <= 1'b0;
      slip_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      rot_q       <= rot_d;
      pos_q       <= pos_d;
      win_q       <= win_d;
      hits_q      <= hits_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      slip_q      <= slip_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.locked    = locked_q;
  assign bus.rot       = rot_q;

`ifdef BARREL_ALIGN_STATS_EN
  assign bus.slip_cnt = slip_q;
`else
  logic unused_slip;
  assign unused_slip = ^slip_q;
`endif

endmodule

// File: tb/tb_barrel_align.sv
// Directed bench for barrel_align: lock at several rotations, miss tolerance,
// loss of lock, idle gaps and reset while locked.
module tb_barrel_align;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  barrel_align_if bus ();

  barrel_align u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic send(input logic v, input logic [7:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] fw(input logic [7:0] s, input int i);
    return (i % 16 == 0) ? s : 8'h00;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    send(1'b0, 8'h00);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    send(1'b1, 8'hA5);
    send(1'b1, 8'hA5);
    checks += 5;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
    if (bus.out_sof !== 1'b0) begin failures++; $display("FAIL reset_out_sof got=%b exp=0", bus.out_sof); end
    if (bus.locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", bus.locked); end
    if (bus.rot !== 3'd0) begin failures++; $display("FAIL reset_rot got=%0d exp=0", bus.rot); end
`ifdef BARREL_ALIGN_STATS_EN
    checks++;
    if (bus.slip_cnt !== 8'h00) begin failures++; $display("FAIL reset_slip got=%h exp=00", bus.slip_cnt); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_lock_rot3();
    logic [7:0] ed;
    logic       es;
    do_reset();
    for (int i = 0; i < 128; i++) begin
      send(1'b1, fw(8'h2D, i));
      if (i == 46) begin
        checks++;
        if (bus.rot !== 3'd2) begin failures++; $display("FAIL rot3_rot_w46 got=%0d exp=2", bus.rot); end
      end
      if (i == 47) begin
        checks++;
        if (bus.rot !== 3'd3) begin failures++; $display("FAIL rot3_rot_w47 got=%0d exp=3", bus.rot); end
      end
      if (i == 95) begin
        checks++;
        if (bus.locked !== 1'b0) begin failures++; $display("FAIL rot3_locked_w95 got=%b exp=0", bus.locked); end
      end
      if (i == 96) begin
        checks++;
        if (bus.locked !== 1'b1) begin failures++; $display("FAIL rot3_locked_w96 got=%b exp=1", bus.locked); end
      end
      if (i >= 112) begin
        es = (i == 112);
        ed = (i == 112) ? 8'hA5 : 8'h00;
        checks += 2;
        if (bus.out_sof !== es) begin failures++; $display("FAIL rot3_sof w%0d got=%b exp=%b", i, bus.out_sof, es); end
        if (bus.out_data !== ed) begin failures++; $display("FAIL rot3_data w%0d got=%h exp=%h", i, bus.out_data, ed); end
      end
    end
  endtask

  task automatic test_miss_recover();
    logic [5:0] badmask;
    logic [7:0] d;
    badmask = 6'b011011;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 16; i++) begin
        d = (i == 0 && !badmask[f]) ? 8'h2D : 8'h00;
        send(1'b1, d);
        if (i == 0) begin
          checks++;
          if (bus.out_sof !== !badmask[f]) begin
            failures++; $display("FAIL miss_sof f%0d got=%b exp=%b", f, bus.out_sof, !badmask[f]);
          end
        end
        if (i == 15) begin
          checks++;
          if (bus.locked !== 1'b1) begin failures++; $display("FAIL miss_locked f%0d got=%b exp=1", f, bus.locked); end
        end
      end
    end
  endtask

  task automatic test_loss();
    logic [7:0] d;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 16; i++) begin
        d = (i == 0 && f >= 3) ? 8'h2D : 8'h00;
        send(1'b1, d);
        if (f == 1 && i == 15) begin
          checks++;
          if (bus.locked !== 1'b1) begin failures++; $display("FAIL loss_locked_2miss got=%b exp=1", bus.locked); end
        end
        if (f == 2 && i == 0) begin
          checks++;
          if (bus.locked !== 1'b0) begin failures++; $display("FAIL loss_locked_3miss got=%b exp=0", bus.locked); end
`ifdef BARREL_ALIGN_STATS_EN
          checks++;
          if (bus.slip_cnt !== 8'd1) begin failures++; $display("FAIL loss_slip got=%0d exp=1", bus.slip_cnt); end
`endif
        end
        if (f == 5 && i == 15) begin
          checks++;
          if (bus.locked !== 1'b0) begin failures++; $display("FAIL relock_early got=%b exp=0", bus.locked); end
        end
        if (f == 6 && i == 0) begin
          checks += 2;
          if (bus.locked !== 1'b1) begin failures++; $display("FAIL relock_locked got=%b exp=1", bus.locked); end
          if (bus.rot !== 3'd3) begin failures++; $display("FAIL relock_rot got=%0d exp=3", bus.rot); end
        end
      end
    end
  endtask

  task automatic test_rot0();
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      d = fw(8'hA5, i);
      send(1'b1, d);
      checks += 2;
      if (bus.out_data !== d) begin failures++; $display("FAIL rot0_data w%0d got=%h exp=%h", i, bus.out_data, d); end
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rot0_valid w%0d got=%b exp=1", i, bus.out_valid); end
      if (i == 47) begin
        checks++;
        if (bus.locked !== 1'b0) begin failures++; $display("FAIL rot0_locked_w47 got=%b exp=0", bus.locked); end
      end
      if (i == 48) begin
        checks += 2;
        if (bus.locked !== 1'b1) begin failures++; $display("FAIL rot0_locked_w48 got=%b exp=1", bus.locked); end
        if (bus.rot !== 3'd0) begin failures++; $display("FAIL rot0_rot got=%0d exp=0", bus.rot); end
      end
    end
  endtask

  task automatic test_gaps();
    logic [7:0] junk;
    do_reset();
    for (int idx = 0; idx < 160; idx++) begin
      for (int g = 0; g < 8 && $urandom_range(0, 1) == 0; g++) begin
        junk = 8'($urandom);
        send(1'b0, junk);
        checks += 2;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL gap_valid idle got=%b exp=0", bus.out_valid); end
        if (bus.out_sof !== 1'b0) begin failures++; $display("FAIL gap_sof idle got=%b exp=0", bus.out_sof); end
      end
      send(1'b1, fw(8'hB4, idx));
      checks++;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL gap_valid w%0d got=%b exp=1", idx, bus.out_valid); end
      if (idx >= 80) begin
        checks++;
        if (bus.out_data !== fw(8'hA5, idx)) begin
          failures++; $display("FAIL gap_data w%0d got=%h exp=%h", idx, bus.out_data, fw(8'hA5, idx));
        end
      end
      if (idx == 127) begin
        checks++;
        if (bus.locked !== 1'b0) begin failures++; $display("FAIL gap_locked_w127 got=%b exp=0", bus.locked); end
      end
      if (idx == 128) begin
        checks += 2;
        if (bus.locked !== 1'b1) begin failures++; $display("FAIL gap_locked_w128 got=%b exp=1", bus.locked); end
        if (bus.rot !== 3'd5) begin failures++; $display("FAIL gap_rot got=%0d exp=5", bus.rot); end
      end
    end
  endtask

  task automatic test_back_to_back();
    checks++;
    if (bus.locked !== 1'b1) begin failures++; $display("FAIL b2b_pre_locked got=%b exp=1", bus.locked); end
    rst = 1'b1;
    send(1'b1, 8'hB4);
    checks += 3;
    if (bus.locked !== 1'b0) begin failures++; $display("FAIL b2b_rst_locked got=%b exp=0", bus.locked); end
    if (bus.rot !== 3'd0) begin failures++; $display("FAIL b2b_rst_rot got=%0d exp=0", bus.rot); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_rst_valid got=%b exp=0", bus.out_valid); end
    rst = 1'b0;
    for (int i = 0; i < 144; i++) begin
      send(1'b1, fw(8'hB4, i));
      if (i == 127) begin
        checks++;
        if (bus.locked !== 1'b0) begin failures++; $display("FAIL b2b_locked_w127 got=%b exp=0", bus.locked); end
      end
      if (i == 128) begin
        checks += 2;
        if (bus.locked !== 1'b1) begin failures++; $display("FAIL b2b_locked_w128 got=%b exp=1", bus.locked); end
        if (bus.rot !== 3'd5) begin failures++; $display("FAIL b2b_rot got=%0d exp=5", bus.rot); end
      end
    end
  endtask

  initial begin
    clk          = 1'b0;
    rst          = 1'b1;
    checks       = 0;
    failures     = 0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #1;
    test_reset();
    test_lock_rot3();
    test_miss_recover();
    test_loss();
    test_rot0();
    test_gaps();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
